// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the PPCPU pipeline sequencer.
//   state_e    - sequencer states (INIT, RUN, DRAIN, HALTED)
//   REG_ZERO   - architectural zero register; never a dependency source
//   DRAIN_CYC  - cycles needed to empty Ex, Mem and Wr before halting
//   src_match  - one source-operand versus one in-flight-writer comparison
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         DRAIN_CYC = 3;

    // True when an instruction reading 'src' depends on a writer of 'dst'.
    // Register 0 is hard-wired, so reading it never waits on anyone.
    function automatic logic src_match(input logic       used,
                                       input logic [4:0] src,
                                       input logic       wr,
                                       input logic [4:0] dst);
        return used && (src != REG_ZERO) && wr && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the PPCPU datapath and its sequencer.
//   master - datapath side: drives ID operands, writer tags, redirect, halt
//            request; receives enables, flushes, Halted and counters.
//   slave  - sequencer side (pipe_hazard_ctrl).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       D_Rs;
    logic [4:0]       D_Rt;
    logic             D_UseRs;
    logic             D_UseRt;
    logic             E_RegWr;
    logic             M_RegWr;
    logic             W_RegWr;
    logic [4:0]       E_Rw;
    logic [4:0]       M_Rw;
    logic [4:0]       W_Rw;
    logic             M_PCSrc;
    logic             Halt_Req;
    logic             PC_En;
    logic             IFID_En;
    logic             IFID_Flush;
    logic             IDEx_Flush;
    logic             ExMem_Flush;
    logic             MemWr_Flush;
    logic             Halted;
    logic [CNT_W-1:0] Stall_Cnt;
    logic [CNT_W-1:0] Flush_Cnt;

    modport master (
        output D_Rs, D_Rt, D_UseRs, D_UseRt,
        output E_RegWr, M_RegWr, W_RegWr, E_Rw, M_Rw, W_Rw,
        output M_PCSrc, Halt_Req,
        input  PC_En, IFID_En, IFID_Flush, IDEx_Flush, ExMem_Flush, MemWr_Flush,
        input  Halted, Stall_Cnt, Flush_Cnt
    );

    modport slave (
        input  D_Rs, D_Rt, D_UseRs, D_UseRt,
        input  E_RegWr, M_RegWr, W_RegWr, E_Rw, M_Rw, W_Rw,
        input  M_PCSrc, Halt_Req,
        output PC_En, IFID_En, IFID_Flush, IDEx_Flush, ExMem_Flush, MemWr_Flush,
        output Halted, Stall_Cnt, Flush_Cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_raw_detect.sv
// raw_detect: combinational read-after-write detector for the ID stage.
//   d_rs/d_rt, d_use_rs/d_use_rt - ID source registers and their use flags
//   e/m/w_reg_wr, e/m/w_rw       - in-flight writers and their destinations
//   hazard                       - ID must wait for an older writer
// Wr counts as a source: the register file is written at the end of the Wr
// cycle while ID reads it combinationally in that same cycle.
module raw_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic       d_use_rs,
    input  logic       d_use_rt,
    input  logic       e_reg_wr,
    input  logic       m_reg_wr,
    input  logic       w_reg_wr,
    input  logic [4:0] e_rw,
    input  logic [4:0] m_rw,
    input  logic [4:0] w_rw,
    output logic       hazard
);

    logic rs_hit_s;
    logic rt_hit_s;

    // Compare each source operand against all three older writers.
    always_comb begin
        rs_hit_s = 1'b0;
        rt_hit_s = 1'b0;
        rs_hit_s = src_match(d_use_rs, d_rs, e_reg_wr, e_rw) ||
                   src_match(d_use_rs, d_rs, m_reg_wr, m_rw) ||
                   src_match(d_use_rs, d_rs, w_reg_wr, w_rw);
        rt_hit_s = src_match(d_use_rt, d_rt, e_reg_wr, e_rw) ||
                   src_match(d_use_rt, d_rt, m_reg_wr, m_rw) ||
                   src_match(d_use_rt, d_rt, w_reg_wr, w_rw);
    end

    assign hazard = rs_hit_s | rt_hit_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencer for the five-stage PPCPU (no forwarding).
//   Clk   - rising-edge clock
//   Rst_n - asynchronous active-low reset
//   bus   - slave side of pipe_hazard_ctrl_if: ID operands, writer tags,
//           M_PCSrc, Halt_Req in; PC_En, IFID_En, four flushes, Halted,
//           Stall_Cnt, Flush_Cnt out.
// Holds bubbles for INIT_CYC cycles after reset, stalls IF/ID on RAW
// hazards, squashes three slots on a Mem redirect, and drains then freezes
// on a halt request. Control outputs are decoded from the registered state
// and the current inputs; state and counters change on the clock edge.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int INIT_CYC = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam int               SEQ_W      = 8;
    localparam logic [SEQ_W-1:0] SEQ_ZERO   = SEQ_W'(0);
    localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);
    localparam logic [SEQ_W-1:0] INIT_LOAD  = SEQ_W'(INIT_CYC - 1);
    localparam logic [SEQ_W-1:0] DRAIN_LOAD = SEQ_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_e           state_r;
    state_e           state_nxt_s;
    logic [SEQ_W-1:0] seq_cnt_r;
    logic [SEQ_W-1:0] seq_cnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic hazard_s;
    logic stall_s;
    logic stall_inc_s;
    logic flush_inc_s;
    logic pc_en_s;
    logic ifid_en_s;
    logic ifid_flush_s;
    logic idex_flush_s;
    logic exmem_flush_s;
    logic memwr_flush_s;
    logic halted_s;

    raw_detect u_raw_detect (
        .d_rs     (bus.D_Rs),
        .d_rt     (bus.D_Rt),
        .d_use_rs (bus.D_UseRs),
        .d_use_rt (bus.D_UseRt),
        .e_reg_wr (bus.E_RegWr),
        .m_reg_wr (bus.M_RegWr),
        .w_reg_wr (bus.W_RegWr),
        .e_rw     (bus.E_Rw),
        .m_rw     (bus.M_Rw),
        .w_rw     (bus.W_Rw),
        .hazard   (hazard_s)
    );

    // A redirect outranks a hazard: the dependent instruction is squashed anyway.
    assign stall_s     = hazard_s & ~bus.M_PCSrc;
    assign stall_inc_s = (state_r == RUN) & stall_s;
    assign flush_inc_s = ((state_r == RUN) | (state_r == DRAIN)) & bus.M_PCSrc;

    // Next-state, sequencing counter and control decode.
    always_comb begin
        state_nxt_s   = state_r;
        seq_cnt_nxt_s = seq_cnt_r;
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        ifid_flush_s  = 1'b1;
        idex_flush_s  = 1'b1;
        exmem_flush_s = 1'b1;
        memwr_flush_s = 1'b1;
        halted_s      = 1'b0;
        case (state_r)
            INIT: begin
                if (seq_cnt_r == SEQ_ZERO) begin
                    state_nxt_s = RUN;
                end else begin
                    seq_cnt_nxt_s = seq_cnt_r - SEQ_ONE;
                end
            end
            RUN: begin
                ifid_flush_s  = 1'b0;
                idex_flush_s  = 1'b0;
                exmem_flush_s = 1'b0;
                memwr_flush_s = 1'b0;
                if (bus.M_PCSrc) begin
                    pc_en_s       = 1'b1;
                    ifid_en_s     = 1'b1;
                    ifid_flush_s  = 1'b1;
                    idex_flush_s  = 1'b1;
                    exmem_flush_s = 1'b1;
                end else if (hazard_s) begin
                    idex_flush_s = 1'b1;
                end else begin
                    pc_en_s   = 1'b1;
                    ifid_en_s = 1'b1;
                end
                if (bus.Halt_Req && !bus.M_PCSrc) begin
                    state_nxt_s   = DRAIN;
                    seq_cnt_nxt_s = DRAIN_LOAD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                // Fetch is closed; only instructions already past IF retire.
                idex_flush_s  = 1'b0;
                exmem_flush_s = 1'b0;
                memwr_flush_s = 1'b0;
                if (bus.M_PCSrc) begin
                    // Capture the target so the resume fetches the right path.
                    pc_en_s       = 1'b1;
                    ifid_en_s     = 1'b1;
                    idex_flush_s  = 1'b1;
                    exmem_flush_s = 1'b1;
                end else if (hazard_s) begin
                    idex_flush_s = 1'b1;
                end else begin
                    pc_en_s = 1'b0;
                end
                // Count down only on cycles where something actually advanced;
                // the cycle that decrements to zero is the last drain cycle.
                if (stall_s) begin
                    seq_cnt_nxt_s = seq_cnt_r;
                end else if (seq_cnt_r <= SEQ_ONE) begin
                    seq_cnt_nxt_s = SEQ_ZERO;
                    state_nxt_s   = HALTED;
                end else begin
                    seq_cnt_nxt_s = seq_cnt_r - SEQ_ONE;
                end
            end
            HALTED: begin
                halted_s = 1'b1;
                if (!bus.Halt_Req) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HALTED;
                end
            end
            default: begin
                state_nxt_s   = INIT;
                seq_cnt_nxt_s = INIT_LOAD;
            end
        endcase
    end

    // State and sequencing counter register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= INIT;
            seq_cnt_r <= INIT_LOAD;
        end else begin
            state_r   <= state_nxt_s;
            seq_cnt_r <= seq_cnt_nxt_s;
        end
    end

    // Saturating performance counters; only reset clears them.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.PC_En       = pc_en_s;
    assign bus.IFID_En     = ifid_en_s;
    assign bus.IFID_Flush  = ifid_flush_s;
    assign bus.IDEx_Flush  = idex_flush_s;
    assign bus.ExMem_Flush = exmem_flush_s;
    assign bus.MemWr_Flush = memwr_flush_s;
    assign bus.Halted      = halted_s;
    assign bus.Stall_Cnt   = stall_cnt_r;
    assign bus.Flush_Cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl. Inputs change
// 1 ns after the rising edge and outputs are checked 1 ns later.
// Flush vector order in checks: {IFID, IDEx, ExMem, MemWr}.
module tb_pipe_hazard_ctrl;

    logic Clk;
    logic Rst_n;
    int   tests;
    int   fails;

    pipe_hazard_ctrl_if #(.CNT_W(16)) ifc ();

    pipe_hazard_ctrl #(.CNT_W(16), .INIT_CYC(4)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (ifc.slave)
    );

    logic [3:0] flushes;
    assign flushes = {ifc.IFID_Flush, ifc.IDEx_Flush, ifc.ExMem_Flush, ifc.MemWr_Flush};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.D_Rs = 5'd0;  ifc.D_Rt = 5'd0;
        ifc.D_UseRs = 1'b0; ifc.D_UseRt = 1'b0;
        ifc.E_RegWr = 1'b0; ifc.M_RegWr = 1'b0; ifc.W_RegWr = 1'b0;
        ifc.E_Rw = 5'd0; ifc.M_Rw = 5'd0; ifc.W_Rw = 5'd0;
        ifc.M_PCSrc = 1'b0;
        ifc.Halt_Req = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge Clk);
        #1;

        // Reset values
        chk("rst_pc_en", 32'(ifc.PC_En), 32'd0);
        chk("rst_ifid_en", 32'(ifc.IFID_En), 32'd0);
        chk("rst_flushes", 32'(flushes), 32'hF);
        chk("rst_halted", 32'(ifc.Halted), 32'd0);
        chk("rst_stall_cnt", 32'(ifc.Stall_Cnt), 32'd0);
        chk("rst_flush_cnt", 32'(ifc.Flush_Cnt), 32'd0);

        // Four bubble cycles after release, then RUN
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("init_pc_en", 32'(ifc.PC_En), 32'd0);
            chk("init_flushes", 32'(flushes), 32'hF);
            tick();
        end
        #1;
        chk("run_pc_en", 32'(ifc.PC_En), 32'd1);
        chk("run_ifid_en", 32'(ifc.IFID_En), 32'd1);
        chk("run_flushes", 32'(flushes), 32'h0);
        chk("run_stall_cnt", 32'(ifc.Stall_Cnt), 32'd0);

        // Writer of r5 directly ahead: stalls while it sits in E, M and W
        ifc.D_Rs = 5'd5; ifc.D_UseRs = 1'b1;
        ifc.E_RegWr = 1'b1; ifc.E_Rw = 5'd5;
        #1;
        chk("stall_e_pc_en", 32'(ifc.PC_En), 32'd0);
        chk("stall_e_ifid_en", 32'(ifc.IFID_En), 32'd0);
        chk("stall_e_flushes", 32'(flushes), 32'h4);
        tick();
        ifc.E_RegWr = 1'b0; ifc.M_RegWr = 1'b1; ifc.M_Rw = 5'd5;
        #1;
        chk("stall_m_pc_en", 32'(ifc.PC_En), 32'd0);
        chk("stall_m_flushes", 32'(flushes), 32'h4);
        tick();
        ifc.M_RegWr = 1'b0; ifc.W_RegWr = 1'b1; ifc.W_Rw = 5'd5;
        #1;
        chk("stall_w_pc_en", 32'(ifc.PC_En), 32'd0);
        chk("stall_w_flushes", 32'(flushes), 32'h4);
        tick();
        ifc.W_RegWr = 1'b0;
        #1;
        chk("stall_done_pc_en", 32'(ifc.PC_En), 32'd1);
        chk("stall_done_flushes", 32'(flushes), 32'h0);
        chk("stall_cnt_3", 32'(ifc.Stall_Cnt), 32'd3);

        // Register 0 never stalls
        ifc.D_Rs = 5'd0; ifc.E_RegWr = 1'b1; ifc.E_Rw = 5'd0;
        #1;
        chk("r0_pc_en", 32'(ifc.PC_En), 32'd1);
        tick();
        // Unused source never stalls
        ifc.D_Rs = 5'd5; ifc.D_UseRs = 1'b0; ifc.E_Rw = 5'd5;
        #1;
        chk("unused_pc_en", 32'(ifc.PC_En), 32'd1);
        tick();
        clear_inputs();
        #1;
        chk("nostall_cnt_3", 32'(ifc.Stall_Cnt), 32'd3);

        // Rt path against an M-stage writer
        ifc.D_Rt = 5'd7; ifc.D_UseRt = 1'b1;
        ifc.M_RegWr = 1'b1; ifc.M_Rw = 5'd7;
        #1;
        chk("rt_stall_pc_en", 32'(ifc.PC_En), 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("rt_stall_cnt_4", 32'(ifc.Stall_Cnt), 32'd4);

        // Redirect concurrent with a hazard: redirect wins
        ifc.D_Rs = 5'd5; ifc.D_UseRs = 1'b1;
        ifc.E_RegWr = 1'b1; ifc.E_Rw = 5'd5;
        ifc.M_PCSrc = 1'b1;
        #1;
        chk("redir_pc_en", 32'(ifc.PC_En), 32'd1);
        chk("redir_ifid_en", 32'(ifc.IFID_En), 32'd1);
        chk("redir_flushes", 32'(flushes), 32'hE);
        tick();
        clear_inputs();
        #1;
        chk("redir_flush_cnt", 32'(ifc.Flush_Cnt), 32'd1);
        chk("redir_stall_cnt", 32'(ifc.Stall_Cnt), 32'd4);

        // Halt request: three drain cycles, then Halted
        ifc.Halt_Req = 1'b1;
        #1;
        chk("halt_req_pc_en", 32'(ifc.PC_En), 32'd1);
        chk("halt_req_halted", 32'(ifc.Halted), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_pc_en", 32'(ifc.PC_En), 32'd0);
            chk("drain_flushes", 32'(flushes), 32'h8);
            chk("drain_halted", 32'(ifc.Halted), 32'd0);
        end
        tick();
        chk("halted_halted", 32'(ifc.Halted), 32'd1);
        chk("halted_pc_en", 32'(ifc.PC_En), 32'd0);
        chk("halted_flushes", 32'(flushes), 32'hF);
        ifc.Halt_Req = 1'b0;
        #1;
        chk("halted_hold", 32'(ifc.Halted), 32'd1);
        tick();
        chk("resume_halted", 32'(ifc.Halted), 32'd0);
        chk("resume_pc_en", 32'(ifc.PC_En), 32'd1);
        chk("resume_ifid_en", 32'(ifc.IFID_En), 32'd1);

        // Long stall: counter saturates at all-ones
        ifc.D_Rs = 5'd5; ifc.D_UseRs = 1'b1;
        ifc.E_RegWr = 1'b1; ifc.E_Rw = 5'd5;
        repeat (65540) tick();
        chk("sat_stall_cnt", 32'(ifc.Stall_Cnt), 32'hFFFF);
        chk("sat_pc_en", 32'(ifc.PC_En), 32'd0);

        // Reset mid-stall clears counters and returns to INIT
        Rst_n = 1'b0;
        #1;
        chk("rst2_stall_cnt", 32'(ifc.Stall_Cnt), 32'd0);
        chk("rst2_flush_cnt", 32'(ifc.Flush_Cnt), 32'd0);
        chk("rst2_flushes", 32'(flushes), 32'hF);
        chk("rst2_pc_en", 32'(ifc.PC_En), 32'd0);
        Rst_n = 1'b1;
        tick();
        chk("rst2_init_pc_en", 32'(ifc.PC_En), 32'd0);
        chk("rst2_init_stall_cnt", 32'(ifc.Stall_Cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencer for the five-stage PPCPU, which has no forwarding. It holds all four pipeline registers in bubbles after reset. It detects read-after-write hazards between the ID-stage instruction and older in-flight writers, and stalls IF/ID until the writer retires. It squashes the three younger stages when a branch or jump redirects in Mem. It also drains and halts the pipeline on a debug request and keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of the performance counters
- INIT_CYC, 4, number of bubble cycles held after reset release

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- D_Rs, D_Rt  in  5 each  ID-stage source registers
- D_UseRs, D_UseRt  in  1 each  ID instruction reads Rs / Rt
- E_RegWr, M_RegWr, W_RegWr  in  1 each  stage holds a register writer
- E_Rw, M_Rw, W_Rw  in  5 each  destination register of that writer
- M_PCSrc  in  1  Mem-stage redirect (taken branch or jump)
- Halt_Req  in  1  level; request drain and halt
- PC_En  out  1  PC loads PCin
- IFID_En  out  1  IF/ID captures
- IFID_Flush, IDEx_Flush, ExMem_Flush, MemWr_Flush  out  1 each  load a bubble (all controls 0)
- Halted  out  1  pipeline empty and frozen
- Stall_Cnt, Flush_Cnt  out  CNT_W each  saturating counters

## Operation
Hazard detection:
- Hazard fires when (D_UseRs & D_Rs≠0 & any X_RegWr & X_Rw==D_Rs, X∈{E,M,W}) or the same condition on Rt.
- Stage W counts as a hazard source because the register file writes at the end of the Wr cycle and ID reads combinationally.

States:
- INIT
  - Entered on reset; a down-counter is loaded with INIT_CYC−1.
  - PC_En=0, IFID_En=0, all four flushes =1.
  - Goes to RUN when the counter reaches 0.
- RUN, normal operation:
  - If M_PCSrc: PC_En=1, IFID_Flush=IDEx_Flush=ExMem_Flush=1, IFID_En=1.
  - Else if hazard (stall): PC_En=0, IFID_En=0, IDEx_Flush=1.
  - Else: PC_En=1, IFID_En=1, no flushes.
  - Halt_Req=1 with no redirect that cycle goes to DRAIN and loads the drain counter with 3.
- DRAIN
  - PC_En=0, IFID_Flush=1.
  - IDEx_Flush=1 during a hazard; otherwise the ID instruction advances.
  - M_PCSrc still forces PC_En=1 plus the three redirect flushes, so the target is captured for resume.
  - The counter decrements each non-hazard cycle and goes to HALTED at 0.
- HALTED
  - PC_En=0, IFID_En=0, all flushes =1, Halted=1.
  - Halt_Req=0 goes to RUN.
- Priority within a cycle: reset > M_PCSrc > hazard > Halt_Req.
- Halt_Req dropping during DRAIN does not abort the drain; HALTED is reached and then exits on the following cycle.

Counters:
- Stall_Cnt +1 per RUN cycle with a hazard and no redirect.
- Flush_Cnt +1 per cycle with M_PCSrc in RUN or DRAIN.
- Both saturate at all-ones and never wrap. Both are cleared only by reset.

## Timing
- Reset values:
  - State INIT, counter INIT_CYC−1.
  - PC_En=0, IFID_En=0, all flushes=1, Halted=0.
  - Stall_Cnt=Flush_Cnt=0.
- Control outputs are combinational from the registered state and current inputs. State and counters update on the rising Clk edge.
- Stall length follows writer position: a dependent instruction directly behind its writer stalls 3 cycles, then 2 for one gap, 1 for two gaps, and 0 beyond that.
- A redirect costs exactly 3 squashed slots. The PC holds the target on the edge after M_PCSrc.
- Halted rises 4 cycles after Halt_Req is sampled in RUN with no hazards: DRAIN takes 3 cycles, then HALTED.
- Rst_n asserted in any state returns to INIT immediately; counters clear asynchronously.

## Structure
- Package pipe_ctrl_pkg: state enum {INIT, RUN, DRAIN, HALTED}, REG_ZERO=5'd0, DRAIN_CYC=3.
- Sub-module raw_detect: purely combinational comparator producing the hazard bit.
- The FSM, counters and output decode stay in pipe_hazard_ctrl.

## Test plan
- Reset release: flushes=1 and PC_En=0 for 4 cycles, then PC_En=1 and IFID_En=1 in RUN; counters read 0.
- D_Rs=5, D_UseRs=1, E_RegWr=1, E_Rw=5, writer advancing E→M→W: exactly 3 stall cycles; Stall_Cnt=3 afterwards.
- Same as above with Rw=0, or with D_UseRs=0: no stall; Stall_Cnt unchanged.
- M_PCSrc=1 concurrent with a hazard: PC_En=1, three flushes=1, no stall; Flush_Cnt +1, Stall_Cnt unchanged.
- Halt_Req=1 in RUN: Halted=1 on the 4th cycle; Halt_Req=0 then gives RUN with PC_En=1 next cycle.
- Force 65540 stall cycles: Stall_Cnt holds at 16'hFFFF; Rst_n pulse mid-stall clears it to 0 and returns to INIT.
